alu_share_arb: RTL

ALU_SHARE_ARB -- requirements
Module: alu_share_arb

---
 rtl/alu_share_arb.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/alu_share_arb.sv
// alu_share_arb
//   Time-shares one external combinational ALU between two requesters.
//   Only one operation is in flight at a time: a command is accepted in
//   IDLE, presented to the ALU for exactly one cycle in EXEC, and its
//   registered result is held in RESP until the owning requester takes it.
//   Contention between the two requesters is resolved round-robin.
//
// Ports
//   clk, rst_n                : clock, asynchronous active-low reset
//   reqN_valid/ready          : command handshake, requester N (N = 0, 1)
//   reqN_op/a/b               : ALU control code and operands
//   rspN_valid/ready          : response handshake, requester N
//   rspN_data/err             : result, undefined-opcode flag
//   alu_ctrl/alu_a/alu_b      : drive the shared ALU (zero outside EXEC)
//   alu_result                : combinational result from the shared ALU
module alu_share_arb #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [3:0]       req0_op,
   input  logic [WIDTH-1:0] req0_a,
   input  logic [WIDTH-1:0] req0_b,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [3:0]       req1_op,
   input  logic [WIDTH-1:0] req1_a,
   input  logic [WIDTH-1:0] req1_b,
   output logic             rsp0_valid,
   input  logic             rsp0_ready,
   output logic [WIDTH-1:0] rsp0_data,
   output logic             rsp0_err,
   output logic             rsp1_valid,
   input  logic             rsp1_ready,
   output logic [WIDTH-1:0] rsp1_data,
   output logic             rsp1_err,
   output logic [3:0]       alu_ctrl,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   input  logic [WIDTH-1:0] alu_result
);

   typedef enum logic [1:0] {
      IDLE,
      EXEC,
      RESP
   } state_t;

   state_t           state_q, state_d;
   logic             ptr_q, ptr_d;     // requester favoured on contention
   logic             id_q, id_d;       // owner of the in-flight operation
   logic [3:0]       op_q, op_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] res_q, res_d;
   logic             err_q, err_d;

   logic             grant;            // requester offered ready in IDLE
   logic             op_defined;
   logic             served;

   // A lone valid requester wins regardless of the pointer; otherwise
   // (both or neither valid) the pointer decides.
   always_comb begin
      grant = ptr_q;
      if (req0_valid && !req1_valid) begin
         grant = 1'b0;
      end else if (req1_valid && !req0_valid) begin
         grant = 1'b1;
      end
   end

   always_comb begin
      case (op_q)
         4'b0000, 4'b0001, 4'b0010, 4'b0011,
         4'b0100, 4'b0101, 4'b1000, 4'b1001: op_defined = 1'b1;
         default:                            op_defined = 1'b0;
      endcase
   end

   always_comb begin
      req0_ready = (state_q == IDLE) && !grant;
      req1_ready = (state_q == IDLE) &&  grant;

      rsp0_valid = (state_q == RESP) && !id_q;
      rsp1_valid = (state_q == RESP) &&  id_q;
      rsp0_data  = rsp0_valid ? res_q : '0;
      rsp1_data  = rsp1_valid ? res_q : '0;
      rsp0_err   = rsp0_valid && err_q;
      rsp1_err   = rsp1_valid && err_q;

      alu_ctrl   = (state_q == EXEC) ? op_q : '0;
      alu_a      = (state_q == EXEC) ? a_q  : '0;
      alu_b      = (state_q == EXEC) ? b_q  : '0;

      served     = id_q ? rsp1_ready : rsp0_ready;
   end

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      id_d    = id_q;
      op_d    = op_q;
      a_d     = a_q;
      b_d     = b_q;
      res_d   = res_q;
      err_d   = err_q;
      case (state_q)
         IDLE: begin
            if (req0_valid && req0_ready) begin
               id_d    = 1'b0;
               op_d    = req0_op;
               a_d     = req0_a;
               b_d     = req0_b;
               state_d = EXEC;
            end else if (req1_valid && req1_ready) begin
               id_d    = 1'b1;
               op_d    = req1_op;
               a_d     = req1_a;
               b_d     = req1_b;
               state_d = EXEC;
            end
         end
         EXEC: begin
            // Undefined opcodes still occupy the ALU slot but report zero.
            res_d   = op_defined ? alu_result : '0;
            err_d   = !op_defined;
            state_d = RESP;
         end
         RESP: begin
            if (served) begin
               ptr_d   = !id_q;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         ptr_q   <= 1'b0;
         id_q    <= 1'b0;
         op_q    <= '0;
         a_q     <= '0;
         b_q     <= '0;
         res_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         id_q    <= id_d;
         op_q    <= op_d;
         a_q     <= a_d;
         b_q     <= b_d;
         res_q   <= res_d;
         err_q   <= err_d;
      end
   end

endmodule
